// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Purpose : Fetch unit owning the PC; reads program bytes over rd/ready and
//           strobes them to the control unit. Option: FETCH_PREFETCH_EN.
// Rev     : 1.0
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              pc_inc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] irin,
    output logic              iri_in,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

`ifdef FETCH_PREFETCH_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_READ     = 2'd1,
        S_DELIVER  = 2'd2,
        S_PREFETCH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_DELIVER = 2'd2
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                iri_in_q, iri_in_d;
    logic [DATA_W-1:0]   irin_q, irin_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   pc_plus1;

`ifdef FETCH_PREFETCH_EN
    logic                pf_valid_q, pf_valid_d;
    logic [DATA_W-1:0]   pf_buf_q, pf_buf_d;
    logic                pend_q, pend_d;
`endif

    assign pc_plus1 = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        iri_in_d   = 1'b0;
        irin_d     = irin_q;
`ifdef FETCH_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_buf_d   = pf_buf_q;
        pend_d     = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef FETCH_PREFETCH_EN
                if (fetch_req && pf_valid_q) begin
                    state_d    = S_DELIVER;
                    iri_in_d   = 1'b1;
                    irin_d     = pf_buf_q;
                    pf_valid_d = 1'b0;
                end else
`endif
                if (fetch_req) begin
                    state_d    = S_READ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_q;
                end else if (pc_inc) begin
                    pc_d = pc_plus1;
`ifdef FETCH_PREFETCH_EN
                    pf_valid_d = 1'b0;
`endif
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    state_d  = S_DELIVER;
                    mem_rd_d = 1'b0;
                    iri_in_d = 1'b1;
                    irin_d   = mem_data;
                end
            end
            S_DELIVER: begin
                pc_d = pc_plus1;
`ifdef FETCH_PREFETCH_EN
                state_d    = S_PREFETCH;
                mem_rd_d   = 1'b1;
                mem_addr_d = pc_plus1;
`else
                state_d    = S_IDLE;
`endif
            end
`ifdef FETCH_PREFETCH_EN
            S_PREFETCH: begin
                // A fetch seen while the prefetch is in flight is served straight from the bus
                if (mem_ready) begin
                    mem_rd_d = 1'b0;
                    if (pend_q || fetch_req) begin
                        state_d  = S_DELIVER;
                        iri_in_d = 1'b1;
                        irin_d   = mem_data;
                        pend_d   = 1'b0;
                    end else begin
                        state_d    = S_IDLE;
                        pf_buf_d   = mem_data;
                        pf_valid_d = 1'b1;
                    end
                end else if (fetch_req) begin
                    pend_d = 1'b1;
                end else if (pc_inc && !pend_q) begin
                    state_d  = S_IDLE;
                    mem_rd_d = 1'b0;
                    pc_d     = pc_plus1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (jump) begin
            state_d  = S_IDLE;
            pc_d     = jump_addr;
            mem_rd_d = 1'b0;
            iri_in_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_valid_d = 1'b0;
            pend_d     = 1'b0;
`endif
        end

`ifdef FETCH_PREFETCH_EN
        busy_d = (state_d != S_IDLE) && (state_d != S_PREFETCH);
`else
        busy_d = (state_d != S_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            iri_in_q   <= 1'b0;
            irin_q     <= '0;
            busy_q     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_buf_q   <= '0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            iri_in_q   <= iri_in_d;
            irin_q     <= irin_d;
            busy_q     <= busy_d;
`ifdef FETCH_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_buf_q   <= pf_buf_d;
            pend_q     <= pend_d;
`endif
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign iri_in   = iri_in_q;
    assign irin     = irin_q;
    assign busy     = busy_q;
    assign pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Bench for instr_fetch: directed and randomized fetch/skip/jump traffic against
// a byte-array memory and a plain PC model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_inc;
    logic        jump;
    logic [15:0] jump_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [7:0]  irin;
    logic        iri_in;
    logic        busy;
    logic [15:0] pc;

    instr_fetch #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .pc_inc    (pc_inc),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .irin      (irin),
        .iri_in    (iri_in),
        .busy      (busy),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change 1ns after the rising edge; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fetch_req = 1'b0;
        pc_inc    = 1'b0;
        jump      = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic do_fetch(input int ws, input bit also_inc);
        logic [15:0] a;
        a = m_pc;
        tick(); clear_inputs(); fetch_req = 1'b1; pc_inc = also_inc;
        smp();
        chk("pc_before", 32'(pc), 32'(a));
        chk("idle_busy", 32'(busy), 0);
        for (int i = 0; i <= ws; i++) begin
            tick();
            fetch_req = 1'($urandom);
            pc_inc    = 1'($urandom);
            mem_ready = (i == ws);
            mem_data  = (i == ws) ? mem[mem_addr] : 8'($urandom);
            smp();
            chk("rd_high", 32'(mem_rd), 1);
            chk("rd_addr", 32'(mem_addr), 32'(a));
            chk("no_early_strobe", 32'(iri_in), 0);
            chk("busy_read", 32'(busy), 1);
        end
        tick();
        fetch_req = 1'($urandom);
        pc_inc    = 1'($urandom);
        mem_ready = 1'($urandom);
        mem_data  = 8'($urandom);
        smp();
        chk("strobe", 32'(iri_in), 1);
        chk("irin", 32'(irin), 32'(mem[a]));
        chk("rd_drop", 32'(mem_rd), 0);
        chk("pc_hold", 32'(pc), 32'(a));
        m_pc = 16'(a + 16'd1);
        tick(); clear_inputs();
        smp();
        chk("strobe_once", 32'(iri_in), 0);
        chk("pc_advance", 32'(pc), 32'(m_pc));
        chk("busy_clear", 32'(busy), 0);
    endtask

    task automatic do_inc();
        tick(); clear_inputs(); pc_inc = 1'b1;
        smp();
        tick(); clear_inputs();
        smp();
        m_pc = 16'(m_pc + 16'd1);
        chk("pc_inc", 32'(pc), 32'(m_pc));
        chk("inc_no_rd", 32'(mem_rd), 0);
    endtask

    task automatic do_jump_idle(input logic [15:0] a);
        tick(); clear_inputs(); jump = 1'b1; jump_addr = a;
        smp();
        tick(); clear_inputs();
        smp();
        m_pc = a;
        chk("jump_pc", 32'(pc), 32'(a));
        chk("jump_busy", 32'(busy), 0);
    endtask

    task automatic do_jump_read(input logic [15:0] a, input int ws, input bit ready_too);
        tick(); clear_inputs(); fetch_req = 1'b1;
        smp();
        for (int i = 0; i < ws; i++) begin
            tick(); clear_inputs();
            smp();
            chk("jr_rd_wait", 32'(mem_rd), 1);
        end
        tick(); clear_inputs();
        jump = 1'b1; jump_addr = a; mem_ready = ready_too; mem_data = mem[mem_addr];
        smp();
        chk("jr_rd_at_jump", 32'(mem_rd), 1);
        tick(); clear_inputs();
        smp();
        m_pc = a;
        chk("jr_rd_drop", 32'(mem_rd), 0);
        chk("jr_no_strobe", 32'(iri_in), 0);
        chk("jr_pc", 32'(pc), 32'(a));
        chk("jr_busy", 32'(busy), 0);
        tick();
        smp();
        chk("jr_no_late_strobe", 32'(iri_in), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_rd"}, 32'(mem_rd), 0);
        chk({tag, "_iri"}, 32'(iri_in), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0]         = 8'hA5;
        mem[1]         = 8'h3C;
        clear_inputs();
        jump_addr = '0;
        mem_data  = '0;
        rst_n     = 1'b0;
        m_pc      = '0;
        smp();
        reset_checks("in_reset");
        chk("in_reset_addr", 32'(mem_addr), 0);
        chk("in_reset_irin", 32'(irin), 0);
        tick(); rst_n = 1'b1;
        smp();
        reset_checks("after_reset");

`ifdef FETCH_PREFETCH_EN
        // fetch at 0 -> prefetch of 1 -> second fetch served one cycle later
        tick(); fetch_req = 1'b1;
        smp();
        tick(); fetch_req = 1'b0; mem_ready = 1'b1; mem_data = mem[mem_addr];
        smp();
        chk("pf_rd0", 32'(mem_addr), 0);
        tick(); mem_ready = 1'b0;
        smp();
        chk("pf_irin0", 32'(irin), 32'h00A5);
        chk("pf_strobe0", 32'(iri_in), 1);
        tick(); mem_ready = 1'b1; mem_data = mem[mem_addr];
        smp();
        chk("pf_rd1", 32'(mem_rd), 1);
        chk("pf_addr1", 32'(mem_addr), 1);
        chk("pf_busy", 32'(busy), 0);
        tick(); clear_inputs(); fetch_req = 1'b1;
        smp();
        tick(); clear_inputs();
        smp();
        chk("pf_strobe1", 32'(iri_in), 1);
        chk("pf_irin1", 32'(irin), 32'h003C);
        // let the next prefetch land, then jump and confirm the buffer is dropped
        tick(); mem_ready = 1'b1; mem_data = mem[mem_addr];
        smp();
        chk("pf_pc2", 32'(pc), 2);
        tick(); clear_inputs(); jump = 1'b1; jump_addr = 16'h0040;
        smp();
        tick(); clear_inputs(); fetch_req = 1'b1;
        smp();
        chk("pf_jump_pc", 32'(pc), 32'h0040);
        tick(); clear_inputs();
        smp();
        chk("pf_discard_no_strobe", 32'(iri_in), 0);
        chk("pf_discard_rd", 32'(mem_rd), 1);
        chk("pf_discard_addr", 32'(mem_addr), 32'h0040);
`else
        do_fetch(0, 1'b0);
        do_fetch(3, 1'b0);
        do_jump_read(16'h1234, 1, 1'b0);
        do_fetch(0, 1'b0);
        do_jump_read(16'h0100, 0, 1'b1);
        do_fetch(2, 1'b0);
        do_jump_idle(16'hFFFF);
        do_inc();
        do_jump_idle(16'hFFFF);
        do_fetch(1, 1'b0);
        do_fetch(0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    do_fetch(int'($urandom_range(0, 3)), 1'($urandom));
                2:       do_inc();
                3:       do_jump_idle(16'($urandom));
                default: do_jump_read(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
            endcase
        end

        // reset pulled while a read is outstanding
        tick(); clear_inputs(); fetch_req = 1'b1;
        smp();
        tick(); clear_inputs();
        smp();
        chk("rst_mid_rd_before", 32'(mem_rd), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_async", 32'(mem_rd), 0);
        chk("rst_mid_busy_async", 32'(busy), 0);
        tick(); rst_n = 1'b1;
        smp();
        m_pc = '0;
        reset_checks("rst_mid");
        tick();
        smp();
        chk("rst_mid_no_strobe", 32'(iri_in), 0);
        do_fetch(0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
